// File: rtl/apb_rw_traffic_gen.sv
// apb_rw_traffic_gen
// APB3 master that writes a configurable data pattern across a range of
// addresses, reads every location back and checks it. It counts mismatches
// and slave errors, latches the address of the first failure and aborts the
// run if the slave holds PREADY low for too long.
module apb_rw_traffic_gen #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter int                NUM_TXN     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                ADDR_STRIDE = 1,
  parameter int                PATTERN     = 0,
  parameter int                MODE        = 0,
  parameter logic [15:0]       SEED        = 16'hA500,
  parameter int                TIMEOUT_CYC = 256
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              start,
  input  logic              init_done,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              timeout
);

  // A one-transaction run still needs a one-bit index.
  localparam int IDX_W = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_TXN - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] SEED_D   = DATA_W'(SEED);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(ADDR_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_SETUP,
    S_ACCESS,
    S_NEXT,
    S_DONE
  } state_t;

  typedef enum logic {
    PH_WRITE,
    PH_READ
  } phase_t;

  state_t            state;
  state_t            state_nxt;
  phase_t            phase;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] cur_addr;
  logic [TO_W-1:0]   tcnt;

  logic              run_start;
  logic              xfer_ok;
  logic              to_hit;
  logic              last_xfer;
  logic              err_hit;
  logic [DATA_W-1:0] exp_data;

  // Data word for transaction i; all arithmetic wraps at DATA_W bits.
  function automatic logic [DATA_W-1:0] pattern_of(input logic [IDX_W-1:0] i);
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] res;
    sum = SEED_D + DATA_W'(i);
    case (PATTERN)
      1:       res = DATA_W'(1) << (int'(i) % DATA_W);
      2:       res = ~sum;
      default: res = sum;
    endcase
    return res;
  endfunction

  // Per-cycle events shared by the FSM and the datapath.
  always_comb begin
    run_start = start && ((state == S_IDLE) || (state == S_DONE));
    xfer_ok   = (state == S_ACCESS) && pready;
    to_hit    = (state == S_ACCESS) && !pready && (tcnt == TO_LAST);
    last_xfer = (phase == PH_READ) && (idx == LAST_IDX);
    exp_data  = pattern_of(idx);
    // A read that both mismatches and reports PSLVERR is one error.
    err_hit   = xfer_ok && (pslverr || ((phase == PH_READ) && (prdata != exp_data)));
  end

  // State register; reset is synchronous and returns straight to IDLE.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (preset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and APB/status outputs, all derived from registers.
  always_comb begin
    // NOTE: every output gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = '0;
    pwdata    = '0;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_WAIT_INIT;
      end
      S_WAIT_INIT: begin
        busy = 1'b1;
        if (init_done) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        busy      = 1'b1;
        psel      = 1'b1;
        state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        busy    = 1'b1;
        psel    = 1'b1;
        penable = 1'b1;
        if (pready)      state_nxt = S_NEXT;
        else if (to_hit) state_nxt = S_DONE;
      end
      S_NEXT: begin
        busy      = 1'b1;
        state_nxt = last_xfer ? S_DONE : S_SETUP;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (err_count == 16'h0000) && !timeout;
        if (start) state_nxt = S_WAIT_INIT;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Address, direction and write data only change in NEXT, so they stay
    // stable from SETUP through every wait state of ACCESS.
    if (psel) begin
      paddr  = cur_addr;
      pwrite = (phase == PH_WRITE);
      pwdata = (phase == PH_WRITE) ? exp_data : '0;
    end
  end

  // Sequencing position, timeout counter and error log.
  always_ff @(posedge pclk) begin
    if (preset) begin
      phase          <= PH_WRITE;
      idx            <= '0;
      cur_addr       <= '0;
      tcnt           <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
    end else begin
      if (run_start) begin
        phase          <= PH_WRITE;
        idx            <= '0;
        cur_addr       <= BASE_ADDR;
        err_count      <= '0;
        first_err_addr <= '0;
        timeout        <= 1'b0;
      end

      // Counts ACCESS cycles; leaving ACCESS clears it for the next transfer.
      if (state == S_ACCESS) tcnt <= tcnt + TO_W'(1);
      else                   tcnt <= '0;

      if (err_hit) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'h0000) first_err_addr <= cur_addr;
      end

      if (to_hit) timeout <= 1'b1;

      // Step to the next transfer; the final read leaves everything as is.
      if ((state == S_NEXT) && !last_xfer) begin
        if (MODE == 1) begin
          if (phase == PH_WRITE) begin
            phase <= PH_READ;
          end else begin
            phase    <= PH_WRITE;
            idx      <= idx + IDX_W'(1);
            cur_addr <= cur_addr + STRIDE_A;
          end
        end else begin
          if ((phase == PH_WRITE) && (idx == LAST_IDX)) begin
            phase    <= PH_READ;
            idx      <= '0;
            cur_addr <= BASE_ADDR;
          end else begin
            idx      <= idx + IDX_W'(1);
            cur_addr <= cur_addr + STRIDE_A;
          end
        end
      end
    end
  end

endmodule
